alu_req_sequencer: RTL
======================

Name: alu_req_sequencer

Overview:
Upstream issue stage for the 4-bit ALU (a, b, 3-bit select, 8-bit result).
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Drives one operation at a time onto the ALU operand/select lines and holds them stable for a programmable settle window.
- Captures the 8-bit result and presents it downstream on a valid/ready response interface, with backpressure.

Parameters:
PTR_W, 2, FIFO pointer width; FIFO depth = 2**PTR_W entries.
SETTLE, 2, number of clock cycles operands are held before the result is sampled; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready at clk edge
req_a  input  4  operand A
req_b  input  4  operand B
req_sel  input  3  ALU select (0 add, 1 sub, 2 mul, 3 div/mod, 4 or, 5 and, 6 xor, 7 shift)
alu_a  output  4  operand A to ALU
alu_b  output  4  operand B to ALU
alu_sl  output  3  select to ALU
alu_out  input  8  ALU result
rsp_valid  output  1  response present
rsp_ready  input  1  downstream accepts response
rsp_data  output  8  captured result
rsp_sel  output  3  select of the op that produced rsp_data
rsp_err  output  1  op error flag
busy  output  1  FIFO non-empty or FSM not IDLE
fifo_count  output  PTR_W+1  current FIFO occupancy

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - alu_a, alu_b, alu_sl, rsp_data, rsp_sel: 0.
  - rsp_valid, rsp_err, busy: 0.
  - fifo_count: 0. FSM in IDLE.
- req_ready = !full && !rst, from registered count (combinational only on the count register).
- Push: req_valid && req_ready at an edge writes {a, b, sel} at the write pointer.
  - No bypass: the earliest pop of that entry is the next edge.
- Pop: occurs only on FSM issue (below).
  - Push and pop on the same edge leave the count unchanged.
  - When full, req_ready is 0 even if a pop happens that edge.
- Pointers wrap modulo 2**PTR_W; fifo_count saturates at 2**PTR_W (full).
- FSM states:
  - IDLE: if count != 0, pop head into alu_a/alu_b/alu_sl, load settle counter with SETTLE, go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle where the counter equals 1, at the edge:
    - rsp_data <= alu_out, rsp_sel <= alu_sl, rsp_err computed;
    - rsp_valid <= 1; go to HOLD.
  - HOLD: rsp_data, rsp_sel and rsp_err are stable while rsp_valid && !rsp_ready. When rsp_ready = 1 at the edge, rsp_valid <= 0, and:
    - if count != 0, pop and load operands on the same edge, go to WAIT;
    - otherwise go to IDLE.
- Latency:
  - Request accepted at edge E (FIFO empty, FSM IDLE): operands driven after E+1, rsp_valid high after E+1+SETTLE.
  - Sustained throughput with rsp_ready = 1: one response per SETTLE+1 cycles.
- alu_a/alu_b/alu_sl change only on a pop edge; they hold their last value in IDLE and HOLD.
- Result is whatever alu_out shows at the capture edge; no width change (8 bits pass through).
- busy = (state != IDLE) || (count != 0).
- Reset mid-operation:
  - FIFO contents are discarded, FSM goes to IDLE, rsp_valid drops on that edge, and the in-flight op is lost.
  - A request presented during the rst cycle is not accepted.

Optional Feature:
ALU_DIVZERO_CHK_EN
- Defined: an op with sel = 3 and b = 0 follows identical timing, but at capture rsp_data = 8'hFF and rsp_err = 1. alu_out is ignored for that op. All other ops give rsp_err = 0.
- Undefined: rsp_err is constant 0 and rsp_data = alu_out for every op, including divide-by-zero.

Test Plan:
- Add: SETTLE = 2, push a = 9, b = 7, sel = 0 at edge E, rsp_ready = 1 → rsp_valid high after E+3 for one cycle, rsp_data = 8'h10, rsp_sel = 0, rsp_err = 0.
- Div/mod: push a = 13, b = 4, sel = 3 → rsp_data = 8'h31 ({q = 3, r = 1}). Back-to-back with mul a = 15, b = 15 → second response 8'hE1 exactly SETTLE+1 cycles after the first.
- Backpressure/full: PTR_W = 2, rsp_ready = 0, push continuously →
  - 5 requests accepted (1 in the operand stage, 4 buffered), then req_ready = 0 and fifo_count = 4;
  - rsp_data stays constant in HOLD;
  - releasing rsp_ready drains responses in push order.
- Simultaneous push/pop: FIFO holding 2 entries, push on the same edge as a HOLD → WAIT pop → fifo_count stays 2.
- Reset mid-op: 3 requests queued, assert rst while in WAIT → next cycle rsp_valid = 0, fifo_count = 0, busy = 0, alu_a/alu_b/alu_sl = 0; no stale response appears afterwards.
- With ALU_DIVZERO_CHK_EN: a = 5, b = 0, sel = 3 → rsp_data = 8'hFF, rsp_err = 1. Without the macro → rsp_err = 0.

Source files
------------

// File: rtl/alu_req_sequencer_if.sv
// Request/ALU/response signal bundle for alu_req_sequencer.
// master = requester + ALU + response sink side, slave = the sequencer.
interface alu_req_sequencer_if #(
  parameter int PTR_W = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_a;
  logic [3:0]       req_b;
  logic [2:0]       req_sel;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_sl;
  logic [7:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [2:0]       rsp_sel;
  logic             rsp_err;
  logic             busy;
  logic [PTR_W:0]   fifo_count;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    input  req_ready, alu_a, alu_b, alu_sl, rsp_valid, rsp_data, rsp_sel,
           rsp_err, busy, fifo_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    output req_ready, alu_a, alu_b, alu_sl, rsp_valid, rsp_data, rsp_sel,
           rsp_err, busy, fifo_count
  );
endinterface

// File: rtl/alu_req_sequencer.sv
// Issue stage for the 4-bit ALU: request FIFO, operand hold for SETTLE cycles, result capture.
// Optional macro ALU_DIVZERO_CHK_EN: div/mod by zero reports 8'hFF with rsp_err = 1.
module alu_req_sequencer #(
  parameter int PTR_W  = 2,
  parameter int SETTLE = 2
) (
  input logic                clk,
  input logic                rst,
  alu_req_sequencer_if.slave bus
);
  localparam int             DEPTH     = 1 << PTR_W;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [3:0]     SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  logic [10:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_settle;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic [2:0]       r_alu_sl;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic [2:0]       r_rsp_sel;
  logic             r_rsp_err;

  logic             w_full;
  logic             w_empty;
  logic             w_req_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_release;
  logic [10:0]      w_head;
  logic [7:0]       w_cap_data;
  logic             w_cap_err;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_req_ready = !w_full && !rst;
  assign w_push      = bus.req_valid && w_req_ready;
  assign w_head      = r_mem[r_rd_ptr];

`ifdef ALU_DIVZERO_CHK_EN
  logic w_divz;
  assign w_divz     = (r_alu_sl == 3'd3) && (r_alu_b == 4'd0);
  assign w_cap_data = w_divz ? 8'hFF : bus.alu_out;
  assign w_cap_err  = w_divz;
`else
  assign w_cap_data = bus.alu_out;
  assign w_cap_err  = 1'b0;
`endif

  // FIFO storage has no reset; resetting the pointers discards its contents
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.req_a, bus.req_b, bus.req_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_settle == 4'd1) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        // Releasing the response and issuing the next op share one edge
        if (bus.rsp_ready) begin
          w_release = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_sl <= '0;
    end else if (w_pop) begin
      r_settle <= SETTLE_LD;
      r_alu_a  <= w_head[10:7];
      r_alu_b  <= w_head[6:3];
      r_alu_sl <= w_head[2:0];
    end else if (r_state == S_WAIT) begin
      r_settle <= r_settle - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_sel   <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_cap_data;
      r_rsp_sel   <= r_alu_sl;
      r_rsp_err   <= w_cap_err;
    end else if (w_release) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sl     = r_alu_sl;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_sel    = r_rsp_sel;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
  assign bus.fifo_count = r_count;
endmodule
